mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_mdu_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// -----------------------------------------------------------------------------
// mdu_ctrl -- multiply/divide unit controller with HI/LO registers.
//
// Accepts mult/multu/div/divu requests and holds busy for a fixed number of
// cycles before committing the result into HI/LO. mthi/mtlo write HI/LO
// directly in a single cycle. The arithmetic itself is evaluated from the
// latched operands at the commit edge; the busy window models the latency
// of the real datapath so the pipeline stall timing is exact.
//
// Parameters:
//   MUL_CYCLES  busy length of mult/multu (1..15)
//   DIV_CYCLES  busy length of div/divu   (1..15)
//
// Optional feature macro: MDU_CANCEL_EN (adds the cancel input).
//
// Ports:
//   clk        clock, all state updates on rising edge
//   reset      asynchronous active-high reset
//   start      request strobe; op/a/b sampled on the same edge
//   op         000 none, 001 mult, 010 multu, 011 div, 100 divu,
//              101 mthi, 110 mtlo, 111 reserved
//   a, b       rs / rt operands
//   cancel     abort in-flight mult/div (only with MDU_CANCEL_EN)
//   busy       operation in flight (registered)
//   done       one-cycle pulse after a mult/div result commits (registered)
//   hi, lo     HI / LO architectural registers
//   dbg_state  current FSM state (0 idle, 1 mul, 2 div)
//
// Handshake: start is a request that is accepted only on an edge where busy
// is low; while busy is high any start is dropped without side effects, so
// busy acts as the inverse of a ready signal. A start on the cycle that done
// is high is accepted (busy is already low then).
// -----------------------------------------------------------------------------
module mdu_ctrl #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
`ifdef MDU_CANCEL_EN
  input  logic        cancel,
`endif
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [1:0]  dbg_state
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  localparam logic [3:0] MUL_N = 4'(MUL_CYCLES);
  localparam logic [3:0] DIV_N = 4'(DIV_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic        sgn_q, sgn_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        cancel_w;

`ifdef MDU_CANCEL_EN
  assign cancel_w = cancel;
`else
  assign cancel_w = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Arithmetic on latched operands. sgn_q selects signed interpretation.
  // ---------------------------------------------------------------------------
  logic [63:0] mul_ext_a, mul_ext_b, prod;
  logic        neg_a, neg_b;
  logic [31:0] mag_a, mag_b, mag_b_safe;
  logic [31:0] uquo, urem, quo, rem;

  assign mul_ext_a = {{32{sgn_q & opa_q[31]}}, opa_q};
  assign mul_ext_b = {{32{sgn_q & opb_q[31]}}, opb_q};
  assign prod      = mul_ext_a * mul_ext_b;

  // Signed division goes through magnitudes so 0x80000000 / -1 needs no
  // special case: |a| = 0x80000000 as unsigned, quotient negates back to it.
  assign neg_a      = sgn_q & opa_q[31];
  assign neg_b      = sgn_q & opb_q[31];
  assign mag_a      = neg_a ? (32'd0 - opa_q) : opa_q;
  assign mag_b      = neg_b ? (32'd0 - opb_q) : opb_q;
  // Divide-by-zero never commits; the substitute divisor only keeps the
  // divider output well defined.
  assign mag_b_safe = (mag_b == 32'd0) ? 32'd1 : mag_b;
  assign uquo       = mag_a / mag_b_safe;
  assign urem       = mag_a % mag_b_safe;
  assign quo        = (neg_a ^ neg_b) ? (32'd0 - uquo) : uquo;
  assign rem        = neg_a ? (32'd0 - urem) : urem;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      opa_q   <= 32'd0;
      opb_q   <= 32'd0;
      sgn_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sgn_q   <= sgn_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sgn_d   = sgn_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          unique case (op)
            OP_MULT, OP_MULTU: begin
              state_d = S_MUL;
              cnt_d   = MUL_N;
              opa_d   = a;
              opb_d   = b;
              sgn_d   = (op == OP_MULT);
              busy_d  = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
              state_d = S_DIV;
              cnt_d   = DIV_N;
              opa_d   = a;
              opb_d   = b;
              sgn_d   = (op == OP_DIV);
              busy_d  = 1'b1;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end

      S_MUL, S_DIV: begin
        if (cancel_w) begin
          // Abort wins over a commit on the same edge.
          state_d = S_IDLE;
          cnt_d   = 4'd0;
          busy_d  = 1'b0;
        end else if (cnt_q <= 4'd1) begin
          // Counter reaches zero on this edge: commit.
          state_d = S_IDLE;
          cnt_d   = 4'd0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (state_q == S_MUL) begin
            hi_d = prod[63:32];
            lo_d = prod[31:0];
          end else if (opb_q != 32'd0) begin
            hi_d = rem;
            lo_d = quo;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mdu_ctrl -- self-checking bench for mdu_ctrl (default 5/10 cycle build).
// Table of directed vectors with constant expectations, a randomized run
// using a 64-bit reference model, and hand-written sequences for mthi/mtlo,
// ignored requests, reset mid-operation and (when built in) cancel.
// Expected HI/LO pairs are pushed to exp_q when a request is driven and
// popped when the DUT finishes the busy window.
// -----------------------------------------------------------------------------
module tb_mdu_ctrl;

  localparam int MUL_CYC = 5;
  localparam int DIV_CYC = 10;

  localparam logic [2:0] OP_NONE  = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;
  localparam logic [2:0] OP_RSVD  = 3'b111;

  // clock / reset
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  mdu_ctrl #(.MUL_CYCLES(MUL_CYC), .DIV_CYCLES(DIV_CYC)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
`ifdef MDU_CANCEL_EN
    .cancel    (cancel),
`endif
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo),
    .dbg_state (dbg_state)
  );

  // scoreboard
  int          vectors = 0;
  int          miscompares = 0;
  logic [63:0] exp_q[$];
  logic [31:0] cur_hi = 32'd0;
  logic [31:0] cur_lo = 32'd0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          cyc;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: returns {hi,lo} after the op given the previous HI/LO.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x,
                                        input logic [31:0] y, input logic [31:0] ph,
                                        input logic [31:0] pl);
    longint sx, sy, q, r;
    logic [63:0] p;
    case (o)
      OP_MULT: begin
        p = longint'($signed(x)) * longint'($signed(y));
        return p;
      end
      OP_MULTU: return {32'd0, x} * {32'd0, y};
      OP_DIV: begin
        if (y == 32'd0) return {ph, pl};
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        q  = sx / sy;
        r  = sx % sy;
        return {r[31:0], q[31:0]};
      end
      OP_DIVU: begin
        if (y == 32'd0) return {ph, pl};
        return {x % y, x / y};
      end
      default: return {ph, pl};
    endcase
  endfunction

  function automatic int cycles_of(input logic [2:0] o);
    return (o == OP_MULT || o == OP_MULTU) ? MUL_CYC : DIV_CYC;
  endfunction

  // driver: caller is at a negedge; returns 1 time unit after the sampling edge
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [63:0] e, input bit push);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = OP_NONE;
    a     = 32'd0;
    b     = 32'd0;
    if (push) exp_q.push_back(e);
  endtask

  // Counts remaining busy cycles, then checks done and the committed result.
  // Ends on the negedge where done should be high.
  task automatic wait_result(input int n, input string name);
    int          cnt;
    bit          hold_ok;
    logic [63:0] e;
    cnt     = 0;
    hold_ok = 1'b1;
    forever begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
      if (done || hi !== cur_hi || lo !== cur_lo) hold_ok = 1'b0;
      if (cnt > 20) break;
    end
    check({name, " busy_len"}, 64'(cnt), 64'(n));
    check({name, " done"}, 64'(done), 64'd1);
    check({name, " hold"}, 64'(hold_ok), 64'd1);
    if (exp_q.size() == 0) begin
      check({name, " sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      check({name, " result"}, {hi, lo}, e);
      cur_hi = e[63:32];
      cur_lo = e[31:0];
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  ro;
    logic [31:0] rx, ry;
    logic [63:0] e;
    bit          quiet_ok;

    tbl[0] = '{OP_MULT,  32'hFFFFFFFE, 32'h00000003, MUL_CYC, 32'hFFFFFFFF, 32'hFFFFFFFA};
    tbl[1] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_CYC, 32'hFFFFFFFE, 32'h00000001};
    tbl[2] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, DIV_CYC, 32'hFFFFFFFF, 32'hFFFFFFFD};
    tbl[3] = '{OP_DIV,   32'h00000005, 32'h00000000, DIV_CYC, 32'hFFFFFFFF, 32'hFFFFFFFD};
    tbl[4] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, DIV_CYC, 32'h00000000, 32'h80000000};
    tbl[5] = '{OP_DIVU,  32'd100,      32'd7,        DIV_CYC, 32'h00000002, 32'h0000000E};
    tbl[6] = '{OP_MULT,  32'h00000007, 32'hFFFFFFFD, MUL_CYC, 32'hFFFFFFFF, 32'hFFFFFFEB};
    tbl[7] = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, DIV_CYC, 32'h00000001, 32'hFFFFFFFD};
    tbl[8] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000010, DIV_CYC, 32'h0000000F, 32'h0FFFFFFF};
    tbl[9] = '{OP_MULTU, 32'h80000000, 32'h00000002, MUL_CYC, 32'h00000001, 32'h00000000};

    reset  = 1'b1;
    start  = 1'b0;
    op     = OP_NONE;
    a      = 32'd0;
    b      = 32'd0;
    cancel = 1'b0;
    repeat (3) @(negedge clk);
    check("rst busy",  64'(busy), 64'd0);
    check("rst done",  64'(done), 64'd0);
    check("rst hi",    64'(hi),   64'd0);
    check("rst lo",    64'(lo),   64'd0);
    check("rst state", 64'(dbg_state), 64'd0);
    reset = 1'b0;

    // Directed table; first issue lands on the first edge after reset release
    // and every following one starts in the done cycle of its predecessor.
    for (int i = 0; i < 10; i++) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b, {tbl[i].ehi, tbl[i].elo}, 1'b1);
      wait_result(tbl[i].cyc, $sformatf("vec%0d", i));
    end

    // mthi then mtlo on consecutive edges
    issue(OP_MTHI, 32'h12345678, 32'd0, 64'd0, 1'b0);
    @(negedge clk);
    check("mthi hi",   64'(hi),   64'h12345678);
    check("mthi lo",   64'(lo),   64'(cur_lo));
    check("mthi busy", 64'(busy), 64'd0);
    check("mthi done", 64'(done), 64'd0);
    cur_hi = 32'h12345678;
    issue(OP_MTLO, 32'h9ABCDEF0, 32'd0, 64'd0, 1'b0);
    @(negedge clk);
    check("mtlo lo",   64'(lo),   64'h9ABCDEF0);
    check("mtlo hi",   64'(hi),   64'h12345678);
    check("mtlo busy", 64'(busy), 64'd0);
    cur_lo = 32'h9ABCDEF0;

    // op none and reserved are ignored
    issue(OP_NONE, 32'hDEADBEEF, 32'd1, 64'd0, 1'b0);
    @(negedge clk);
    check("none busy", 64'(busy), 64'd0);
    check("none hilo", {hi, lo}, {cur_hi, cur_lo});
    issue(OP_RSVD, 32'hDEADBEEF, 32'd1, 64'd0, 1'b0);
    @(negedge clk);
    check("rsvd busy", 64'(busy), 64'd0);
    check("rsvd hilo", {hi, lo}, {cur_hi, cur_lo});

    // start while busy is dropped
    issue(OP_MULTU, 32'd3, 32'd4, 64'd12, 1'b1);
    @(negedge clk);
    check("ign busy", 64'(busy), 64'd1);
    start = 1'b1;
    op    = OP_DIVU;
    a     = 32'd100;
    b     = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = OP_NONE;
    wait_result(MUL_CYC - 1, "ignored");
    @(negedge clk);
    check("ign after busy", 64'(busy), 64'd0);
    check("ign after done", 64'(done), 64'd0);

    // Randomized back-to-back ops against the model
    for (int i = 0; i < 8; i++) begin
      ro = 3'($urandom_range(1, 4));
      rx = $urandom;
      ry = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      if (ry != 32'd0 && $urandom_range(0, 1) == 1) ry = 32'($urandom_range(1, 300));
      e = model(ro, rx, ry, cur_hi, cur_lo);
      issue(ro, rx, ry, e, 1'b1);
      wait_result(cycles_of(ro), $sformatf("rnd%0d op%0d", i, ro));
    end

    // Reset three cycles into a div
    issue(OP_DIV, 32'd100, 32'd7, model(OP_DIV, 32'd100, 32'd7, cur_hi, cur_lo), 1'b1);
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("mid rst busy",  64'(busy), 64'd0);
    check("mid rst done",  64'(done), 64'd0);
    check("mid rst hilo",  {hi, lo}, 64'd0);
    check("mid rst state", 64'(dbg_state), 64'd0);
    exp_q.delete();
    cur_hi = 32'd0;
    cur_lo = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    quiet_ok = 1'b1;
    repeat (15) begin
      @(negedge clk);
      if (done || busy || hi !== 32'd0 || lo !== 32'd0) quiet_ok = 1'b0;
    end
    check("post rst quiet", 64'(quiet_ok), 64'd1);
    issue(OP_MULT, 32'd6, 32'd7, 64'd42, 1'b1);
    wait_result(MUL_CYC, "post rst mult");

`ifdef MDU_CANCEL_EN
    // cancel on cycle 2 of a mult
    issue(OP_MULT, 32'd5, 32'd5, 64'd25, 1'b1);
    @(negedge clk);
    @(negedge clk);
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    @(negedge clk);
    check("cancel busy", 64'(busy), 64'd0);
    check("cancel hilo", {hi, lo}, {cur_hi, cur_lo});
    void'(exp_q.pop_back());
    quiet_ok = 1'b1;
    repeat (8) begin
      if (done || busy) quiet_ok = 1'b0;
      @(negedge clk);
    end
    check("cancel no done", 64'(quiet_ok), 64'd1);
    // cancel while idle does not block a start
    cancel = 1'b1;
    issue(OP_MULT, 32'd2, 32'd3, 64'd6, 1'b1);
    cancel = 1'b0;
    wait_result(MUL_CYC, "cancel idle");
`endif

    check("sb drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
